// File: rtl/posit_pkg.sv
// ---------------------------------------------------------------------------
// posit_pkg
// Shared definitions for the iterative posit divider:
//   - log2 / bs_of : ceiling log2, used to derive the regime-count width Bs
//   - nar_const    : NaR bit pattern (only the MSB set) for an n-bit posit
//   - zero_const   : zero bit pattern for an n-bit posit
//   - div_state_t  : divider FSM states
// ---------------------------------------------------------------------------
package posit_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Regime-count width for an n-bit posit.
  function automatic int bs_of(input int n);
    return log2(n);
  endfunction

  function automatic logic [63:0] nar_const(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] zero_const(input int n);
    logic [63:0] z;
    z        = '0;
    z[n - 1] = 1'b0;
    return z;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DIVIDE = 2'd2,
    PACK   = 2'd3
  } div_state_t;

endpackage

// File: rtl/DSR_right_N_S.sv
// ---------------------------------------------------------------------------
// DSR_right_N_S
// Logarithmic logical right shifter (zero fill).
//   a : N-bit input word
//   b : S-bit shift amount
//   c : a >> b
// ---------------------------------------------------------------------------
module DSR_right_N_S #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c
);

  logic [N-1:0] stage [0:S];

  assign stage[0] = a;

  // Stage gi shifts by 2**gi when bit gi of the amount is set.
  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    assign stage[gi+1] = b[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
  end

  assign c = stage[S];

endmodule

// File: rtl/data_extract.sv
// ---------------------------------------------------------------------------
// data_extract
// Field decoder for a non-negative posit (sign already removed).
//   in     : posit word, MSB expected to be 0
//   rc     : regime polarity (1 = run of ones)
//   regime : run of ones -> run length - 1; run of zeros -> run length
//   exp    : exponent field (zero where it ran off the end of the word)
//   mant   : {hidden 1, fraction} left-aligned, N-es bits
// ---------------------------------------------------------------------------
module data_extract
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int es = 3
) (
  input  logic [N-1:0]            in,
  output logic                    rc,
  output logic [bs_of(N)-1:0]     regime,
  output logic [es-1:0]           exp,
  output logic [N-es-1:0]         mant
);

  localparam int Bs = bs_of(N);

  logic [Bs:0]  run;
  logic         stop;
  logic [N-2:0] body;
  logic         unused_sign;

  assign rc          = in[N-2];
  assign unused_sign = in[N-1];

  // Length of the leading run of regime bits.
  always_comb begin
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (in[i] == rc)) run = run + 1'b1;
      else                        stop = 1'b1;
    end
  end

  // Drop the run and its terminator; exponent then fraction follow.
  assign body   = in[N-2:0] << (run + 1'b1);
  assign regime = Bs'(rc ? (run - 1'b1) : run);
  assign exp    = body[N-2 -: es];
  assign mant   = {1'b1, body[N-2-es:0]};

endmodule

// File: rtl/posit_div_encode.sv
// ---------------------------------------------------------------------------
// posit_div_encode
// Combinational posit packer for the divider.
//   sign    : result sign
//   scale   : signed binary scale (regime * 2**es + exponent)
//   mant    : normalised quotient, MSB is the hidden 1
//   rem_nz  : final division remainder is non-zero
//   posit   : packed result, magnitude clamped to [minpos, maxpos]
// Build option POSIT_DIV_ROUND_NEAREST_EN: round-to-nearest-even on the
// packed magnitude; otherwise the magnitude is truncated.
// ---------------------------------------------------------------------------
module posit_div_encode
  import posit_pkg::*;
#(
  parameter int N    = 16,
  parameter int es   = 3,
  parameter int ITER = N - es + 2
) (
  input  logic                              sign,
  input  logic signed [bs_of(N)+es+1:0]     scale,
  input  logic [ITER-1:0]                   mant,
  input  logic                              rem_nz,
  output logic [N-1:0]                      posit
);

  localparam int Bs = bs_of(N);
  localparam int SW = Bs + es + 2;
  // regime terminator + exponent + fraction + room for the largest shift
  localparam int W  = 1 + es + (ITER - 1) + N;
  localparam logic signed [SW-1:0] KMAX = SW'(N - 2);
  localparam logic signed [SW-1:0] KMIN = -SW'(N - 2);
  localparam logic [N-2:0] MAXMAG = '1;
  localparam logic [N-2:0] MINMAG = (N-1)'(1);

  logic signed [SW-1:0] k;
  logic signed [SW-1:0] len;
  logic [es-1:0]        e;
  logic                 rb;
  logic                 ovf, unf;
  logic [W-1:0]         vec, flip, sh_in, sh_out, packed_w;
  logic [N-2:0]         mag, mag_r, mag_f;
  logic                 guard, sticky;
  logic                 unused_bits;

  assign k   = scale >>> es;
  assign e   = scale[es-1:0];
  assign rb  = ~k[SW-1];
  assign ovf = k > KMAX;
  assign unf = k < KMIN;
  // Run length: k+1 ones for k >= 0, -k zeros for k < 0.
  assign len = rb ? (k + 1'b1) : (-k);

  // The shifter zero-fills; inverting before and after makes it fill with
  // the regime bit while leaving the payload intact.
  assign vec   = {~rb, e, mant[ITER-2:0], {N{1'b0}}};
  assign flip  = {W{rb}};
  assign sh_in = vec ^ flip;

  DSR_right_N_S #(.N(W), .S(Bs)) u_shift (
    .a (sh_in),
    .b (len[Bs-1:0]),
    .c (sh_out)
  );

  assign packed_w = sh_out ^ flip;
  assign mag      = packed_w[W-1 -: N-1];
  assign guard    = packed_w[W-N];
  assign sticky   = (|packed_w[W-N-1:0]) | rem_nz;

  assign unused_bits = ^{mant[ITER-1], len[SW-1:Bs]};

`ifdef POSIT_DIV_ROUND_NEAREST_EN
  logic round_up;
  // Incrementing only ever moves away from zero; maxpos is never exceeded.
  assign round_up = guard & (sticky | mag[0]) & ~(&mag);
  assign mag_r    = mag + (N-1)'(round_up);
`else
  logic unused_round;
  assign unused_round = ^{guard, sticky};
  assign mag_r        = mag;
`endif

  assign mag_f = ovf ? MAXMAG : (unf ? MINMAG : mag_r);
  assign posit = sign ? (~{1'b0, mag_f} + 1'b1) : {1'b0, mag_f};

endmodule

// File: rtl/posit_div_iter.sv
// ---------------------------------------------------------------------------
// posit_div_iter
// Iterative posit<N,es> divider, result = in1 / in2, using radix-2 restoring
// mantissa division. One operation in flight; fixed latency ITER+2 cycles
// from the accepting edge to the done edge.
//   aclk, aresetn : clock, asynchronous active-low reset
//   in1, in2      : dividend / divisor posits, captured when start is
//                   accepted in IDLE
//   start         : request, ignored while busy
//   busy          : operation in progress
//   result        : quotient posit, held until the next done
//   inf, zero     : result is NaR / zero
//   done          : one-cycle completion pulse
// Build option POSIT_DIV_ROUND_NEAREST_EN selects round-to-nearest-even
// instead of truncation in the packer.
// ---------------------------------------------------------------------------
module posit_div_iter
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int es = 3
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic         busy,
  output logic [N-1:0] result,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int Bs   = bs_of(N);
  localparam int ITER = N - es + 2;
  localparam int SW   = Bs + es + 2;
  localparam int MW   = N - es;
  localparam int CW   = log2(ITER);
  localparam logic [N-1:0] NAR  = N'(nar_const(N));
  localparam logic [N-1:0] ZERO = N'(zero_const(N));

  div_state_t           state_q, state_d;
  logic [N-1:0]         a_q, a_d, b_q, b_d;
  logic                 sign_q, sign_d;
  logic                 nar_q, nar_d;
  logic                 zro_q, zro_d;
  logic signed [SW-1:0] scale_q, scale_d;
  logic [MW-1:0]        div_q, div_d;
  logic [MW:0]          rem_q, rem_d;
  logic [ITER-1:0]      quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0]         result_q, result_d;
  logic                 inf_q, inf_d, zero_q, zero_d, done_q, done_d, busy_q, busy_d;

  // ---------------- operand decode ----------------
  logic [N-1:0]         a_abs, b_abs;
  logic                 rc1, rc2;
  logic [Bs-1:0]        reg1, reg2;
  logic [es-1:0]        exp1, exp2;
  logic [MW-1:0]        mant1, mant2;
  logic signed [SW-1:0] r1, r2, sc1, sc2;

  assign a_abs = a_q[N-1] ? (~a_q + 1'b1) : a_q;
  assign b_abs = b_q[N-1] ? (~b_q + 1'b1) : b_q;

  data_extract #(.N(N), .es(es)) u_ext1 (
    .in(a_abs), .rc(rc1), .regime(reg1), .exp(exp1), .mant(mant1)
  );
  data_extract #(.N(N), .es(es)) u_ext2 (
    .in(b_abs), .rc(rc2), .regime(reg2), .exp(exp2), .mant(mant2)
  );

  assign r1  = rc1 ? SW'(reg1) : -SW'(reg1);
  assign r2  = rc2 ? SW'(reg2) : -SW'(reg2);
  // Low es bits of r << es are zero, so OR inserts the exponent.
  assign sc1 = (r1 <<< es) | SW'(exp1);
  assign sc2 = (r2 <<< es) | SW'(exp2);

  // ---------------- divide step ----------------
  logic        q_bit;
  logic [MW:0] rem_sub;

  assign q_bit   = rem_q >= {1'b0, div_q};
  assign rem_sub = rem_q - {1'b0, div_q};

  // ---------------- normalise + pack ----------------
  logic [ITER-1:0]      q_norm;
  logic signed [SW-1:0] scale_pk;
  logic [N-1:0]         enc_out;

  // Quotient lies in (0.5, 2); a clear MSB means one left shift.
  assign q_norm   = quo_q[ITER-1] ? quo_q : {quo_q[ITER-2:0], 1'b0};
  assign scale_pk = scale_q - SW'(!quo_q[ITER-1]);

  posit_div_encode #(.N(N), .es(es), .ITER(ITER)) u_enc (
    .sign   (sign_q),
    .scale  (scale_pk),
    .mant   (q_norm),
    .rem_nz (rem_q != '0),
    .posit  (enc_out)
  );

  // ---------------- FSM ----------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    nar_d    = nar_q;
    zro_d    = zro_q;
    scale_d  = scale_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          busy_d  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sign_d  = a_q[N-1] ^ b_q[N-1];
        nar_d   = (a_q == NAR) || (b_q == NAR) || (b_q == ZERO);
        zro_d   = (a_q == ZERO);
        scale_d = sc1 - sc2;
        div_d   = mant2;
        rem_d   = {1'b0, mant1};
        quo_d   = '0;
        cnt_d   = '0;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        rem_d = (q_bit ? rem_sub : rem_q) << 1;
        quo_d = {quo_q[ITER-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = PACK;
      end
      PACK: begin
        if (nar_q) begin
          result_d = NAR;
          inf_d    = 1'b1;
          zero_d   = 1'b0;
        end else if (zro_q) begin
          result_d = ZERO;
          inf_d    = 1'b0;
          zero_d   = 1'b1;
        end else begin
          result_d = enc_out;
          inf_d    = 1'b0;
          zero_d   = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      nar_q    <= 1'b0;
      zro_q    <= 1'b0;
      scale_q  <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      nar_q    <= nar_d;
      zro_q    <= zro_d;
      scale_q  <= scale_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign result = result_q;
  assign inf    = inf_q;
  assign zero   = zero_q;
  assign done   = done_q;

endmodule

// File: tb/tb_posit_div_iter.sv
// ---------------------------------------------------------------------------
// tb_posit_div_iter
// Directed bench for posit_div_iter (posit<16,3>). Expected results are
// queued when an operation is issued and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_posit_div_iter;

  localparam int N   = 16;
  localparam int LAT = 17;

  logic         aclk    = 1'b0;
  logic         aresetn = 1'b0;
  logic         start   = 1'b0;
  logic [N-1:0] in1     = '0;
  logic [N-1:0] in2     = '0;
  logic         busy, inf, zero, done;
  logic [N-1:0] result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] res;
    logic         inf;
    logic         zero;
  } exp_t;

  exp_t sb[$];

  posit_div_iter #(.N(N), .es(3)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in1     (in1),
    .in2     (in2),
    .start   (start),
    .busy    (busy),
    .result  (result),
    .inf     (inf),
    .zero    (zero),
    .done    (done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one division, wait (bounded) for done and score it.
  // restart_at > 0 re-asserts start with other operands at that cycle.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] er, input logic ei, input logic ez,
                        input int restart_at);
    int   n;
    int   busy_n;
    exp_t e;
    e.tag = tag; e.res = er; e.inf = ei; e.zero = ez;
    sb.push_back(e);

    @(negedge aclk);
    in1 = a; in2 = b; start = 1'b1;
    @(negedge aclk);
    start  = 1'b0;
    n      = 1;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == restart_at) begin
        start = 1'b1; in1 = ~a; in2 = b ^ 16'h0100;
      end else begin
        start = 1'b0;
      end
      @(negedge aclk);
      n++;
      if (done !== 1'b1 && busy === 1'b1) busy_n++;
    end
    start = 1'b0;

    check({tag, " latency"}, 32'(n - 1), 32'(LAT));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(LAT));
    e = sb.pop_front();
    check({e.tag, " result"}, 32'(result), 32'(e.res));
    check({e.tag, " inf"}, 32'(inf), 32'(e.inf));
    check({e.tag, " zero"}, 32'(zero), 32'(e.zero));
    check({e.tag, " busy_at_done"}, 32'(busy), 32'd0);
    $display("[TB] %s in1=%h in2=%h result=%h inf=%b zero=%b latency=%0d",
             tag, a, b, result, inf, zero, n - 1);
    @(negedge aclk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;

    // Reset state
    @(negedge aclk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset inf", 32'(inf), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Main function
    run_op("div_2_1",     16'h4400, 16'h4000, 16'h4400, 1'b0, 1'b0, 0);
    run_op("div_1_2",     16'h4000, 16'h4400, 16'h3C00, 1'b0, 1'b0, 0);
    run_op("div_1p5_m1",  16'h4200, 16'hC000, 16'hBE00, 1'b0, 1'b0, 0);
    run_op("div_1_1p5",   16'h4000, 16'h4200, 16'h3D55, 1'b0, 1'b0, 0);
    run_op("div_m1_m2",   16'hC000, 16'hBC00, 16'h3C00, 1'b0, 1'b0, 0);

    // Specials
    run_op("div_by_zero", 16'h4000, 16'h0000, 16'h8000, 1'b1, 1'b0, 0);
    run_op("zero_num",    16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 0);
    run_op("nar_by_zero", 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 0);
    run_op("nar_num",     16'h8000, 16'h4000, 16'h8000, 1'b1, 1'b0, 0);

    // Saturation and range edges
    run_op("sat_max",     16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 0);
    run_op("sat_min",     16'h0001, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("maxpos_by_1", 16'h7FFF, 16'h4000, 16'h7FFF, 1'b0, 1'b0, 0);
    run_op("minpos_by_m1",16'h0001, 16'hC000, 16'hFFFF, 1'b0, 1'b0, 0);

    // start while busy is ignored; exactly one done
    run_op("restart_ign", 16'h4400, 16'h4000, 16'h4400, 1'b0, 1'b0, 5);
    dones = 0;
    repeat (25) begin
      @(negedge aclk);
      if (done === 1'b1) dones++;
    end
    check("restart extra_done", 32'(dones), 32'd0);

    // Reset in the middle of an operation
    @(negedge aclk);
    in1 = 16'h4200; in2 = 16'h4000; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (7) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    dones = 0;
    repeat (25) begin
      @(negedge aclk);
      if (done === 1'b1) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    $display("[TB] abort in1=4200 in2=4000 result=%h dones=%0d", result, dones);

    // Normal operation after reset release
    run_op("after_reset", 16'h4200, 16'h4000, 16'h4200, 1'b0, 1'b0, 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
